reg_ctrl: RTL and testbench

//  Command decoder and initiator for the regfile register port. It consumes host bytes

---
 rtl/reg_ctrl_pkg.sv | 33 +++
 rtl/reg_ctrl.sv | 104 ++++++++++
 tb/tb_reg_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_ctrl_pkg.sv
// Shared types and constants for the register-port command decoder.
package reg_ctrl_pkg;

    localparam int unsigned REG_NUM_DEF = 6;
    localparam int unsigned ADDR_W      = 3;
    localparam int unsigned BYTE_W      = 8;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_RD_FETCH,
        ST_RD_SEND,
        ST_RD_WAIT,
        ST_DISCARD
    } state_e;

    // Burst pointer step: wraps to 0 after the last implemented register or at 7.
    function automatic logic [ADDR_W-1:0] ptr_wrap(input logic [ADDR_W-1:0] ptr,
                                                   input int unsigned       reg_num);
        if (ptr == ADDR_W'(reg_num - 1) || ptr == {ADDR_W{1'b1}}) begin
            return '0;
        end
        return ptr + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/reg_ctrl.sv
// Host command decoder driving the regfile port and returning read bytes to the SPI slave.
// Optional REG_CTRL_AUTO_INC_EN: burst bytes walk the register pointer; otherwise it stays fixed.
module reg_ctrl
    import reg_ctrl_pkg::*;
#(
    parameter int unsigned REG_NUM    = REG_NUM_DEF,
    parameter int unsigned DATA_WIDTH = BYTE_W
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  byte_vld_i,
    input  logic [DATA_WIDTH-1:0] byte_data_i,
    input  logic                  frame_end_i,
    output logic                  reg_wr_en_o,
    output logic [ADDR_W-1:0]     reg_wr_addr_o,
    output logic [DATA_WIDTH-1:0] reg_wr_data_o,
    output logic [ADDR_W-1:0]     reg_rd_addr_o,
    input  logic [DATA_WIDTH-1:0] reg_rd_data_i,
    output logic                  tx_vld_o,
    output logic [DATA_WIDTH-1:0] tx_data_o
);

    state_e            state;
    logic [ADDR_W-1:0] ptr;

    op_e               op_c;
    logic [ADDR_W-1:0] cmd_addr_c;
    logic [ADDR_W-1:0] ptr_adv_c;
    logic              in_range_c;
    logic              unused_bits_c;

    assign op_c          = op_e'(byte_data_i[7:6]);
    assign cmd_addr_c    = byte_data_i[ADDR_W-1:0];
    assign unused_bits_c = ^byte_data_i[5:3];
    assign in_range_c    = (32'(ptr) < REG_NUM);

`ifdef REG_CTRL_AUTO_INC_EN
    assign ptr_adv_c = ptr_wrap(ptr, REG_NUM);
`else
    assign ptr_adv_c = ptr;
`endif

    // Frame FSM; strobes default low every cycle so each pulse lasts exactly one cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            reg_wr_en_o   <= 1'b0;
            reg_wr_addr_o <= '0;
            reg_wr_data_o <= '0;
            reg_rd_addr_o <= '0;
            tx_vld_o      <= 1'b0;
            tx_data_o     <= '0;
        end else begin
            reg_wr_en_o <= 1'b0;
            tx_vld_o    <= 1'b0;
            if (frame_end_i) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (byte_vld_i) begin
                            ptr <= cmd_addr_c;
                            case (op_c)
                                OP_WRITE: state <= ST_WR_DATA;
                                OP_READ:  state <= ST_RD_FETCH;
                                default:  state <= ST_DISCARD;
                            endcase
                        end
                    end
                    ST_WR_DATA: begin
                        if (byte_vld_i) begin
                            // Out-of-range targets are skipped silently but still advance.
                            if (in_range_c) begin
                                reg_wr_en_o   <= 1'b1;
                                reg_wr_addr_o <= ptr;
                                reg_wr_data_o <= byte_data_i;
                            end
                            ptr <= ptr_adv_c;
                        end
                    end
                    ST_RD_FETCH: begin
                        reg_rd_addr_o <= ptr;
                        state         <= ST_RD_SEND;
                    end
                    ST_RD_SEND: begin
                        tx_data_o <= in_range_c ? reg_rd_data_i : '0;
                        tx_vld_o  <= 1'b1;
                        state     <= ST_RD_WAIT;
                    end
                    ST_RD_WAIT: begin
                        if (byte_vld_i) begin
                            ptr   <= ptr_adv_c;
                            state <= ST_RD_FETCH;
                        end
                    end
                    ST_DISCARD: state <= ST_DISCARD;
                    default:    state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reg_ctrl.sv
// Directed bench for reg_ctrl with a static regfile model and strobe/response monitors.
module tb_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       byte_vld;
    logic [7:0] byte_data;
    logic       frame_end;
    logic       reg_wr_en;
    logic [2:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic [2:0] reg_rd_addr;
    logic [7:0] reg_rd_data;
    logic       tx_vld;
    logic [7:0] tx_data;

    logic [7:0] regs [8];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         last_byte_cyc = 0;
    int         wb = 0;
    int         tb_i = 0;

    logic [10:0] wr_q[$];
    int          wr_cyc_q[$];
    logic [7:0]  tx_q[$];
    int          tx_cyc_q[$];

    reg_ctrl dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .byte_vld_i    (byte_vld),
        .byte_data_i   (byte_data),
        .frame_end_i   (frame_end),
        .reg_wr_en_o   (reg_wr_en),
        .reg_wr_addr_o (reg_wr_addr),
        .reg_wr_data_o (reg_wr_data),
        .reg_rd_addr_o (reg_rd_addr),
        .reg_rd_data_i (reg_rd_data),
        .tx_vld_o      (tx_vld),
        .tx_data_o     (tx_data)
    );

    always #5 clk = ~clk;

    assign reg_rd_data = regs[reg_rd_addr];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reg_wr_en) begin
            wr_q.push_back({reg_wr_addr, reg_wr_data});
            wr_cyc_q.push_back(cyc);
        end
        if (tx_vld) begin
            tx_q.push_back(tx_data);
            tx_cyc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        last_byte_cyc = cyc;
        byte_vld  = 1'b1;
        byte_data = b;
        @(negedge clk);
        byte_vld  = 1'b0;
        idle(3);
    endtask

    task automatic end_frame();
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        idle(2);
    endtask

    task automatic mark();
        wb   = wr_q.size();
        tb_i = tx_q.size();
    endtask

    task automatic expect_wr(input string tag, input int idx, input logic [2:0] a,
                             input logic [7:0] d);
        check(tag, 32'(wr_q[wb + idx]), 32'({a, d}));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_wr_en"},   32'(reg_wr_en),   32'h0);
        check({tag, "_wr_addr"}, 32'(reg_wr_addr), 32'h0);
        check({tag, "_wr_data"}, 32'(reg_wr_data), 32'h0);
        check({tag, "_rd_addr"}, 32'(reg_rd_addr), 32'h0);
        check({tag, "_tx_vld"},  32'(tx_vld),      32'h0);
        check({tag, "_tx_data"}, 32'(tx_data),     32'h0);
    endtask

    initial begin
        int b0;
        int b1;
        regs[0] = 8'h01; regs[1] = 8'h12; regs[2] = 8'h00; regs[3] = 8'h00;
        regs[4] = 8'h00; regs[5] = 8'h00; regs[6] = 8'h5A; regs[7] = 8'hEE;
        rst_n = 1'b0; byte_vld = 1'b0; byte_data = 8'h00; frame_end = 1'b0;
        idle(3);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        idle(2);

        // Single write
        mark();
        send_byte(8'h40);
        send_byte(8'h12);
        b0 = last_byte_cyc;
        end_frame();
        check("t1_count", 32'(wr_q.size() - wb), 32'd1);
        expect_wr("t1_wr0", 0, 3'd0, 8'h12);
        check("t1_lat", 32'(wr_cyc_q[wb] - b0), 32'd1);
        check("t1_hold", 32'({reg_wr_en, reg_wr_addr, reg_wr_data}), 32'({1'b0, 3'd0, 8'h12}));

        // Two-byte burst
        mark();
        send_byte(8'h44);
        send_byte(8'h3F);
        send_byte(8'h07);
        end_frame();
        check("t2_count", 32'(wr_q.size() - wb), 32'd2);
        expect_wr("t2_wr0", 0, 3'd4, 8'h3F);
`ifdef REG_CTRL_AUTO_INC_EN
        expect_wr("t2_wr1", 1, 3'd5, 8'h07);
`else
        expect_wr("t2_wr1", 1, 3'd4, 8'h07);
`endif

        // Read of an unimplemented register returns zero
        mark();
        send_byte(8'h87);
        end_frame();
        check("rng_count", 32'(tx_q.size() - tb_i), 32'd1);
        check("rng_data",  32'(tx_q[tb_i]), 32'h00);

        // Read with dummy byte
        mark();
        send_byte(8'h80);
        b0 = last_byte_cyc;
        send_byte(8'hFF);
        b1 = last_byte_cyc;
        idle(1);
        end_frame();
        check("t3_count", 32'(tx_q.size() - tb_i), 32'd2);
        check("t3_tx0", 32'(tx_q[tb_i]), 32'h01);
`ifdef REG_CTRL_AUTO_INC_EN
        check("t3_tx1", 32'(tx_q[tb_i + 1]), 32'h12);
`else
        check("t3_tx1", 32'(tx_q[tb_i + 1]), 32'h01);
`endif
        check("t3_lat0", 32'(tx_cyc_q[tb_i] - b0), 32'd3);
        check("t3_lat1", 32'(tx_cyc_q[tb_i + 1] - b1), 32'd3);
        check("t3_nowr", 32'(wr_q.size() - wb), 32'd0);

        // Burst across the last register
        mark();
        send_byte(8'h45);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        end_frame();
        check("t4_count", 32'(wr_q.size() - wb), 32'd3);
        expect_wr("t4_wr0", 0, 3'd5, 8'hAA);
`ifdef REG_CTRL_AUTO_INC_EN
        expect_wr("t4_wr1", 1, 3'd0, 8'hBB);
        expect_wr("t4_wr2", 2, 3'd1, 8'hCC);
`else
        expect_wr("t4_wr1", 1, 3'd5, 8'hBB);
        expect_wr("t4_wr2", 2, 3'd5, 8'hCC);
`endif

        // Reserved opcode frame is discarded, next frame works
        mark();
        send_byte(8'hC0);
        send_byte(8'h55);
        check("t5_discard", 32'(wr_q.size() - wb + tx_q.size() - tb_i), 32'd0);
        end_frame();
        send_byte(8'h41);
        send_byte(8'h66);
        end_frame();
        check("t5_count", 32'(wr_q.size() - wb), 32'd1);
        expect_wr("t5_wr0", 0, 3'd1, 8'h66);

        // frame_end wins over a simultaneous byte
        mark();
        send_byte(8'h43);
        byte_vld = 1'b1; byte_data = 8'h99; frame_end = 1'b1;
        @(negedge clk);
        byte_vld = 1'b0; frame_end = 1'b0;
        idle(6);
        check("fe_nowr", 32'(wr_q.size() - wb), 32'd0);
        check("fe_notx", 32'(tx_q.size() - tb_i), 32'd0);

        // Reset between WRITE command and its data byte
        mark();
        send_byte(8'h42);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero_outputs("t6");
        rst_n = 1'b1;
        idle(1);
        send_byte(8'h33);
        end_frame();
        check("t6_nowr", 32'(wr_q.size() - wb), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
